// File: rtl/bus_master.sv
// Bus initiator: fetches {src,dst} move instructions from program ROM, reads src over
// the shared register bus and writes the value to dst. PC and HALT are pseudo-registers
// on the same address map, giving jumps and stop without extra opcodes.
module bus_master #(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ROM_ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-2:0] PC_ADDR        = (DATA_WIDTH-1)'(7'h7E),
    parameter logic [DATA_WIDTH-2:0] HALT_ADDR      = (DATA_WIDTH-1)'(7'h7F)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    output logic                      rom_rd,
    input  logic [2*DATA_WIDTH-1:0]   rom_data,
    output logic [DATA_WIDTH-1:0]     addr_bus,
    output logic [DATA_WIDTH-1:0]     data_bus_in,
    input  logic [DATA_WIDTH-1:0]     data_bus_out,
    output logic                      halt
);

    localparam int unsigned REG_AW = DATA_WIDTH - 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] src;
        logic [DATA_WIDTH-1:0] dst;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0]  pc_q, pc_d;
    instr_t                     ir_q, ir_d;
    logic [DATA_WIDTH-1:0]      dreg_q, dreg_d;
    logic [DATA_WIDTH-1:0]      addr_bus_d;
    logic [DATA_WIDTH-1:0]      data_bus_in_d;
    logic                       rom_rd_d;
    logic                       halt_d;
    logic [REG_AW-1:0]          src_q, dst_q;
    logic                       unused_ir_top;

    // Register fields of the current instruction; the top bit of each byte is don't-care.
    assign src_q         = ir_q.src[REG_AW-1:0];
    assign dst_q         = ir_q.dst[REG_AW-1:0];
    assign unused_ir_top = ir_q.src[DATA_WIDTH-1] ^ ir_q.dst[DATA_WIDTH-1];

    // ROM address always tracks the program counter.
    assign rom_addr = pc_q;

    // Sequencer next state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        dreg_d        = dreg_q;
        addr_bus_d    = '0;
        data_bus_in_d = '0;
        rom_rd_d      = 1'b0;
        halt_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = rom_data;
                pc_d    = pc_q + ROM_ADDR_WIDTH'(1);
                state_d = S_READ;
            end
            S_READ: begin
                // PC reads come from the sequencer itself; the bus value is ignored.
                dreg_d  = (src_q == PC_ADDR) ? DATA_WIDTH'(pc_q) : data_bus_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (dst_q == PC_ADDR) pc_d = ROM_ADDR_WIDTH'(dreg_q);
                if (dst_q == HALT_ADDR) state_d = S_HALT;
                else if (run)           state_d = S_FETCH;
                else                    state_d = S_IDLE;
            end
            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        unique case (state_d)
            S_READ: begin
                addr_bus_d = {1'b0, ir_d.src[REG_AW-1:0]};
            end
            S_WRITE: begin
                addr_bus_d    = {1'b1, ir_d.dst[REG_AW-1:0]};
                data_bus_in_d = dreg_d;
            end
            default: begin
                addr_bus_d    = '0;
                data_bus_in_d = '0;
            end
        endcase

        rom_rd_d = (state_d == S_FETCH);
        halt_d   = (state_d == S_HALT);
    end

    // State, datapath and output registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            dreg_q      <= '0;
            addr_bus    <= '0;
            data_bus_in <= '0;
            rom_rd      <= 1'b0;
            halt        <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            dreg_q      <= dreg_d;
            addr_bus    <= addr_bus_d;
            data_bus_in <= data_bus_in_d;
            rom_rd      <= rom_rd_d;
            halt        <= halt_d;
        end
    end

endmodule
